// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: miniRISC register file, 2**ADDR_WIDTH x DATA_WIDTH.
// Two combinational read ports (rs, rt), one synchronous write port.
// Register 0 is hardwired to zero; register SP_INDEX resets to SP_RESET.
// wr_count counts committed writes since reset and saturates at all-ones.
// Optional: define REGFILE_WRITE_BYPASS_EN for same-cycle write-through
// forwarding to the read ports.
module reg_file_2r1w #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              ADDR_WIDTH = 5,
  parameter int unsigned              SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0]    SP_RESET   = 32'h0000_03FC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [15:0]           wr_count
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  commit;

  // A write commits only outside reset and never to register 0.
  assign commit = wr_en && (wr_addr != '0) && !rst;

  // Storage array: reset image, then committed writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i[ADDR_WIDTH-1:0]] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Saturating count of committed writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (commit && (wr_count != '1)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Combinational read ports; index 0 always reads zero.
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    // commit already excludes rst and index 0, so it gates forwarding exactly.
    if (commit && (rs_addr == wr_addr)) rs_data = wr_data;
    if (commit && (rt_addr == wr_addr)) rt_data = wr_data;
`endif
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: the driver computes expected read
// data and write count from an array model, queues them, and a negedge
// monitor compares them against the DUT.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en;
  logic [15:0] wr_count;

  reg_file_2r1w #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .SP_INDEX   (29),
    .SP_RESET   (32'h0000_03FC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [32];
  int unsigned model_cnt;
  int          tests = 0;
  int          fails = 0;

  // Expected read value of one port this cycle, from the model.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic r,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!r && we && wa != 5'd0 && wa == a) return wd;
`endif
    return model[a];
  endfunction

  // Drive one cycle; optionally queue expectations; then advance the model.
  task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic chk, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rs_addr = ra; rt_addr = rb;
    if (chk) begin
      e.rs   = exp_read(ra, r, we, wa, wd);
      e.rt   = exp_read(rb, r, we, wa, wd);
      e.cnt  = (model_cnt > 65535) ? 16'hFFFF : model_cnt[15:0];
      e.name = nm;
      sb.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29] = 32'h0000_03FC;
      model_cnt = 0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
      model_cnt++;
    end
  endtask

  // Monitor: outputs are combinational, so every queued cycle is checked.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (rs_data !== e.rs) begin
        fails++;
        $display("FAIL %s rs_data: got %h expected %h", e.name, rs_data, e.rs);
      end
      tests++;
      if (rt_data !== e.rt) begin
        fails++;
        $display("FAIL %s rt_data: got %h expected %h", e.name, rt_data, e.rt);
      end
      tests++;
      if (wr_count !== e.cnt) begin
        fails++;
        $display("FAIL %s wr_count: got %h expected %h", e.name, wr_count, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    model_cnt = 0;

    // Reset image on every index, both ports.
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "reset");
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, "reset_val");

    // Basic write then read on both ports.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, "wr5");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, "rd5");

    // Register 0 write is discarded and not counted.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, "wr0");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "rd0");

    // Same-cycle read of the register being written.
    cycle(1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 5'd0, 5'd0, 1'b1, "wr7a");
    cycle(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b1, "rdw7");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b1, "rd7");

    // Reset wins over a simultaneous write.
    cycle(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd7, 1'b1, "rst_coll");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd29, 1'b1, "rd3");

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      cycle(r, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, "rand");
    end

    // Saturation of wr_count.
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "sat_rst");
    for (int n = 0; n < 65540; n++)
      cycle(1'b0, 1'b1, 5'd1, $urandom, 5'd1, 5'($urandom_range(0, 31)), 1'b1, "sat");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd29, 1'b1, "sat_end");
    cycle(1'b0, 1'b1, 5'd2, 32'hCAFE_F00D, 5'd2, 5'd1, 1'b1, "sat_more");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd1, 1'b1, "sat_hold");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
